// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder decoder with signed position, direction and error count
// Optional debounce filter compiled in with QUAD_DEBOUNCE_EN.
module quad_decoder #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  output logic [WIDTH-1:0] position,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam logic [1:0] ST_WARM0 = 2'd0;
  localparam logic [1:0] ST_WARM1 = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  logic             r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic [1:0]       r_state;
  logic [1:0]       r_prev_ab;
  logic [WIDTH-1:0] r_position;
  logic             r_dir, r_step, r_err;
  logic [7:0]       r_err_count;

  logic [1:0] w_sync_ab, w_acc_ab;
  logic [1:0] w_cur_idx, w_prev_idx, w_delta;
  logic       w_settled;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_s1 <= 1'b0;
      r_a_s2 <= 1'b0;
      r_b_s1 <= 1'b0;
      r_b_s2 <= 1'b0;
    end else begin
      r_a_s1 <= A;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= B;
      r_b_s2 <= r_b_s1;
    end
  end

  assign w_sync_ab = {r_a_s2, r_b_s2};

`ifdef QUAD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] r_db_cnt, w_db_next;
  logic [1:0]    r_db_cand, r_acc_ab;

  // Count how many consecutive samples have matched the candidate, saturating at the threshold.
  always_comb begin
    w_db_next = CW'(1);
    if (w_sync_ab == r_db_cand) begin
      if (r_db_cnt == CW'(DEBOUNCE_CYCLES)) w_db_next = r_db_cnt;
      else                                  w_db_next = r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_db_cand <= 2'b00;
      r_db_cnt  <= '0;
      r_acc_ab  <= 2'b00;
    end else begin
      r_db_cand <= w_sync_ab;
      r_db_cnt  <= w_db_next;
      if (w_db_next == CW'(DEBOUNCE_CYCLES)) r_acc_ab <= w_sync_ab;
    end
  end

  assign w_acc_ab  = r_acc_ab;
  assign w_settled = (r_acc_ab == w_sync_ab);
`else
  assign w_acc_ab  = w_sync_ab;
  assign w_settled = 1'b1;
`endif

  // Gray order 00,10,11,01 mapped to 0..3 so a step is a +/-1 index difference.
  assign w_cur_idx  = {w_acc_ab[0], w_acc_ab[1] ^ w_acc_ab[0]};
  assign w_prev_idx = {r_prev_ab[0], r_prev_ab[1] ^ r_prev_ab[0]};
  assign w_delta    = w_cur_idx - w_prev_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WARM0;
      r_prev_ab   <= 2'b00;
      r_position  <= '0;
      r_dir       <= 1'b0;
      r_step      <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_step <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_WARM0: r_state <= ST_WARM1;
        ST_WARM1: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_prev_ab <= w_acc_ab;
          if (w_settled) r_state <= ST_RUN;
        end
        default: begin
          r_prev_ab <= w_acc_ab;
          case (w_delta)
            2'd1: begin
              r_step     <= 1'b1;
              r_dir      <= 1'b1;
              r_position <= r_position + 1'b1;
            end
            2'd3: begin
              r_step     <= 1'b1;
              r_dir      <= 1'b0;
              r_position <= r_position - 1'b1;
            end
            2'd2: begin
              r_err <= 1'b1;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
            default: ;
          endcase
        end
      endcase
      if (clr) r_position <= '0;
    end
  end

  assign position  = r_position;
  assign dir       = r_dir;
  assign step      = r_step;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder
module tb_quad_decoder;

`ifdef QUAD_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int HOLD = DEB + 1;

  logic        clk = 1'b0;
  logic        rst_n, A, B, clr;
  logic [15:0] position;
  logic        dir, step, err;
  logic [7:0]  err_count;

  quad_decoder #(.WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clr(clr),
    .position(position), .dir(dir), .step(step), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [2:0]  q[$];
  logic [1:0]  m_ab;
  logic [15:0] m_pos;
  logic        m_dir;
  int          m_ec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gidx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  task automatic drive_ab(input logic [1:0] ab);
    logic [1:0] d;
    d = gidx(ab) - gidx(m_ab);
    case (d)
      2'd1: begin m_pos = m_pos + 16'd1; m_dir = 1'b1; q.push_back(3'b101); end
      2'd3: begin m_pos = m_pos - 16'd1; m_dir = 1'b0; q.push_back(3'b100); end
      2'd2: begin if (m_ec != 255) m_ec++; q.push_back({2'b01, m_dir}); end
      default: ;
    endcase
    m_ab = ab;
    {A, B} = ab;
  endtask

  task automatic cycle();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (step || err) begin
      if (q.size() == 0) chk("spurious_pulse", {30'd0, step, err}, 32'd0);
      else begin
        e = q.pop_front();
        chk("pulse_step_err_dir", {29'd0, step, err, dir}, {29'd0, e});
      end
    end
  endtask

  task automatic hold(input int n);
    repeat (n) cycle();
  endtask

  logic [1:0] seq_fwd [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] seq_rev [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  int         n;

  initial begin
    rst_n = 1'b0; clr = 1'b0; A = 1'b1; B = 1'b1;
    m_ab = 2'b11; m_pos = 16'd0; m_dir = 1'b0; m_ec = 0;
    hold(3);
    chk("reset_position", position, 0);
    chk("reset_dir", dir, 0);
    chk("reset_step", step, 0);
    chk("reset_err", err, 0);
    chk("reset_err_count", err_count, 0);

    // Release with AB=11: must load silently.
    rst_n = 1'b1;
    hold(12 + DEB);
    chk("release_nonzero_pos", position, 0);
    chk("release_nonzero_errcnt", err_count, 0);

    // A pending 11->01 step is abandoned by a reset.
    {A, B} = 2'b01;
    cycle();
    rst_n = 1'b0;
    hold(2);
    {A, B} = 2'b00; m_ab = 2'b00;
    cycle();
    rst_n = 1'b1;
    hold(12 + DEB);
    chk("reset_abandon_pos", position, 0);

    for (int i = 0; i < 4; i++) begin drive_ab(seq_fwd[i]); hold(8 + DEB); end
    chk("fwd_position", position, 4);
    chk("fwd_dir", dir, 1);
    chk("fwd_err_count", err_count, 0);
    chk("fwd_all_steps_seen", q.size(), 0);

    clr = 1'b1; cycle(); clr = 1'b0; m_pos = 16'd0;
    chk("clr_position", position, 0);
    chk("clr_keeps_dir", dir, 1);

    for (int i = 0; i < 4; i++) begin drive_ab(seq_rev[i]); hold(8 + DEB); end
    chk("rev_position", position, 16'hFFFC);
    chk("rev_dir", dir, 0);
    chk("rev_all_steps_seen", q.size(), 0);

    // clr on the very edge that decodes a step.
    drive_ab(2'b10);
    hold(2 + DEB);
    clr = 1'b1;
    cycle();
    chk("clr_coincident_step", step, 1);
    clr = 1'b0; m_pos = 16'd0;
    chk("clr_coincident_pos", position, 0);
    chk("clr_coincident_dir", dir, 1);
    drive_ab(2'b11); hold(HOLD);
    drive_ab(2'b01); hold(HOLD);
    drive_ab(2'b00); hold(8 + DEB);
    chk("after_clr_pos", position, m_pos);

    drive_ab(2'b11); hold(8 + DEB);
    chk("err_first_count", err_count, 1);
    chk("err_first_pos", position, m_pos);
    chk("err_first_dir", dir, m_dir);
    for (int i = 1; i < 300; i++) begin
      drive_ab((i % 2 == 1) ? 2'b00 : 2'b11);
      hold(HOLD);
    end
    hold(8 + DEB);
    chk("err_saturate", err_count, 255);
    chk("err_model_count", err_count, m_ec);
    chk("err_pos_unchanged", position, m_pos);

`ifndef QUAD_DEBOUNCE_EN
    clr = 1'b1; cycle(); clr = 1'b0; m_pos = 16'd0;
    for (int i = 0; i < 32767; i++) begin drive_ab(seq_fwd[i % 4]); cycle(); end
    hold(6);
    chk("wrap_max_pos", position, 16'h7FFF);
    drive_ab(2'b00); hold(6);
    chk("wrap_to_min", position, 16'h8000);
    drive_ab(2'b01); hold(6);
    chk("wrap_back_to_max", position, 16'h7FFF);
    chk("wrap_model", position, m_pos);
`else
    // Two-cycle glitch on A must be filtered out.
    {A, B} = {~m_ab[1], m_ab[0]};
    hold(2);
    {A, B} = m_ab;
    hold(12);
    chk("deb_glitch_pos", position, m_pos);
    drive_ab({~m_ab[1], m_ab[0]});
    n = 0;
    while (!step && n < 20) begin cycle(); n++; end
    chk("deb_latency", n, 3 + DEB);
    hold(10);
    chk("deb_step_pos", position, m_pos);
`endif

    hold(10);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
